// File: rtl/fnd_bus_pkg.sv
// Shared definitions for the FND register-bus arbiter.
// Holds the arbiter FSM state encoding, requester indices, and the
// FND peripheral register offsets (FCR and FDR).
package fnd_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam logic [31:0] FND_FCR_OFS = 32'h0;
    localparam logic [31:0] FND_FDR_OFS = 32'h4;

endpackage

// File: rtl/fnd_rr_pick2.sv
// Two-way combinational grant selector.
// Ports:
//   req         - request vector, bit i = requester i
//   last_grant  - requester that owned the previous completed transaction
//   grant_valid - at least one request is pending
//   grant_idx   - winning requester index
// Parameter FIXED_PRIO: 0 = round-robin on ties, 1 = requester 0 wins ties.
module fnd_rr_pick2
    import fnd_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = REQ_M0;
        if (req == 2'b11) begin
            // On a tie, round-robin hands the bus to whoever did not go last.
            grant_idx = (FIXED_PRIO != 0) ? REQ_M0 : ~last_grant;
        end else if (req[1]) begin
            grant_idx = REQ_M1;
        end
    end

endmodule

// File: rtl/fnd_bus_arbiter.sv
// Two-requester arbiter/sequencer for the FND peripheral register bus.
// Serialises requester 0 (CPU path) and requester 1 (hardware source) onto
// one cs/wr/addr/wdata/rdata slave port, one full transaction per grant:
// IDLE (arbitrate + latch) -> ACCESS (s_cs=1, capture s_rdata) -> DONE (ready).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   m*_req/wr/addr/wdata        - requester transaction inputs (held until ready)
//   m*_ready, m*_rdata          - one-cycle completion pulse and registered read data
//   s_cs/s_wr/s_addr/s_wdata    - slave request outputs (zero outside ACCESS)
//   s_rdata                     - slave read data, combinational from s_addr
//   busy                        - high in ACCESS and DONE
module fnd_bus_arbiter
    import fnd_bus_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,
    output logic          s_cs,
    output logic          s_wr,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    output logic          busy
);

    state_t        state, state_nxt;
    logic          owner;
    logic          last_grant;
    logic          lat_wr;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          grant_valid;
    logic          grant_idx;

    fnd_rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Latched transaction, per-requester read data and fairness history.
    // NOTE: rdata registers are reset explicitly because they are visible
    // outputs; they are flops, not a memory, so a reset costs nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= REQ_M0;
            last_grant <= REQ_M1;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        lat_wr    <= (grant_idx == REQ_M1) ? m1_wr    : m0_wr;
                        lat_addr  <= (grant_idx == REQ_M1) ? m1_addr  : m0_addr;
                        lat_wdata <= (grant_idx == REQ_M1) ? m1_wdata : m0_wdata;
                    end
                end
                ST_ACCESS: begin
                    // Captured for writes too, so the owner always sees fresh data.
                    if (owner == REQ_M1) m1_rdata <= s_rdata;
                    else                 m0_rdata <= s_rdata;
                end
                ST_DONE: last_grant <= owner;
                default: ;
            endcase
        end
    end

    // Outputs decode from state alone, so an asynchronous reset drops s_cs
    // and the readys immediately.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        s_cs     = 1'b0;
        s_wr     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_ACCESS: begin
                s_cs    = 1'b1;
                s_wr    = lat_wr;
                s_addr  = lat_addr;
                s_wdata = lat_wdata;
            end
            ST_DONE: begin
                m0_ready = (owner == REQ_M0);
                m1_ready = (owner == REQ_M1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fnd_bus_arbiter.sv
// Bench for fnd_bus_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority; both share the requester stimulus and each has its own FND slave.
module tb_fnd_bus_arbiter;
    import fnd_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  s_cs, s_wr, m0_ready, m1_ready, busy;
    logic [31:0] s_addr[2], s_wdata[2], s_rdata[2], m0_rdata[2], m1_rdata[2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fnd_bus_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_ready(m0_ready[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_ready(m1_ready[g]), .m1_rdata(m1_rdata[g]),
            .s_cs(s_cs[g]), .s_wr(s_wr[g]), .s_addr(s_addr[g]), .s_wdata(s_wdata[g]),
            .s_rdata(s_rdata[g]), .busy(busy[g])
        );

        // FND slave: two 8-bit registers, read back zero-extended.
        logic [7:0] fcr, fdr;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                fcr <= 8'h0;
                fdr <= 8'h0;
            end else if (s_cs[g] && s_wr[g]) begin
                if (s_addr[g][2]) fdr <= s_wdata[g][7:0];
                else              fcr <= s_wdata[g][7:0];
            end
        end
        assign s_rdata[g] = {24'h0, (s_addr[g][2] ? fdr : fcr)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction is "age" cycles old after its grant
    // (1 = slave access, 2 = ready); the peripheral contents are tracked too.
    int          m_age[2];
    logic        m_own[2], m_last[2], m_wr[2];
    logic [31:0] m_addr[2], m_wdata[2], m_rd0[2], m_rd1[2];
    logic [7:0]  m_reg[2][2];
    logic [31:0] m_rv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_age[d] = 0; m_own[d] = 1'b0; m_last[d] = 1'b1; m_wr[d] = 1'b0;
                m_addr[d] = 0; m_wdata[d] = 0; m_rd0[d] = 0; m_rd1[d] = 0;
                m_reg[d][0] = 8'h0; m_reg[d][1] = 8'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_age[d] == 0) begin
                    if (m0_req || m1_req) begin
                        if (m0_req && m1_req) m_own[d] = (d == 1) ? 1'b0 : !m_last[d];
                        else                  m_own[d] = m1_req;
                        m_wr[d]    = m_own[d] ? m1_wr    : m0_wr;
                        m_addr[d]  = m_own[d] ? m1_addr  : m0_addr;
                        m_wdata[d] = m_own[d] ? m1_wdata : m0_wdata;
                        m_age[d]   = 1;
                    end
                end else if (m_age[d] == 1) begin
                    m_rv = {24'h0, m_reg[d][m_addr[d][2]]};
                    if (m_own[d]) m_rd1[d] = m_rv;
                    else          m_rd0[d] = m_rv;
                    if (m_wr[d]) m_reg[d][m_addr[d][2]] = m_wdata[d][7:0];
                    m_age[d] = 2;
                end else begin
                    m_last[d] = m_own[d];
                    m_age[d]  = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic acc, dn;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            acc = (m_age[d] == 1);
            dn  = (m_age[d] == 2);
            check($sformatf("s_cs[%0d]", d),     s_cs[d],     acc);
            check($sformatf("s_wr[%0d]", d),     s_wr[d],     acc & m_wr[d]);
            check($sformatf("s_addr[%0d]", d),   s_addr[d],   acc ? m_addr[d] : 32'h0);
            check($sformatf("s_wdata[%0d]", d),  s_wdata[d],  acc ? m_wdata[d] : 32'h0);
            check($sformatf("m0_ready[%0d]", d), m0_ready[d], dn & !m_own[d]);
            check($sformatf("m1_ready[%0d]", d), m1_ready[d], dn & m_own[d]);
            check($sformatf("m0_rdata[%0d]", d), m0_rdata[d], m_rd0[d]);
            check($sformatf("m1_rdata[%0d]", d), m1_rdata[d], m1_rdata_exp(d));
            check($sformatf("busy[%0d]", d),     busy[d],     m_age[d] != 0);
        end
    end

    function automatic logic [31:0] m1_rdata_exp(input int d);
        return m_rd1[d];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (i) begin m1_wr = wr; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1; end
        else   begin m0_wr = wr; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1; end
    endtask

    // One handshake on the round-robin instance; counts other-requester readys.
    task automatic do_txn(input bit i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int other_rdy);
        bit got;
        got = 1'b0;
        other_rdy = 0;
        rd = '0;
        set_req(i, wr, addr, wdata);
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if ((i ? m1_ready[0] : m0_ready[0]) == 1'b1) begin
                got = 1'b1;
                rd = i ? m1_rdata[0] : m0_rdata[0];
            end
            if ((i ? m0_ready[0] : m1_ready[0]) == 1'b1) other_rdy++;
        end
        check("txn_completed", {31'h0, got}, 32'h1);
        step();
        if (i) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    logic [31:0] rd;
    int          oth, r0cnt, r1cnt;
    bit          own_q0[$], own_q1[$];
    int          cs_t[$];
    bit          saw0, saw1;

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = FND_FCR_OFS; m0_wdata = 0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = FND_FCR_OFS; m1_wdata = 0;

        // Reset held with m0_req high: everything quiet.
        step(); step();
        check("rst_s_cs", s_cs[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_m0_ready", m0_ready[0], 1'b0);
        check("rst_m0_rdata", m0_rdata[0], 32'h0);
        rst = 1'b0;
        step();
        check("rel_s_cs_n1", s_cs[0], 1'b1);
        step();
        check("rel_m0_ready_n2", m0_ready[0], 1'b1);
        step();
        m0_req = 1'b0;
        step();

        // m0 write FDR = 1234 (slave keeps the low byte, 0xD2).
        set_req(0, 1'b1, FND_FDR_OFS, 32'd1234);
        step();
        check("wr_s_cs", s_cs[0], 1'b1);
        check("wr_s_wr", s_wr[0], 1'b1);
        check("wr_s_addr", s_addr[0], 32'h4);
        check("wr_s_wdata", s_wdata[0], 32'd1234);
        step();
        check("wr_s_cs_once", s_cs[0], 1'b0);
        check("wr_m0_ready", m0_ready[0], 1'b1);
        check("wr_m1_ready", m1_ready[0], 1'b0);
        step();
        m0_req = 1'b0;
        check("wr_m0_ready_once", m0_ready[0], 1'b0);
        step();

        // FCR = 1 via m0, then m1 reads it back.
        do_txn(0, 1'b1, FND_FCR_OFS, 32'h1, rd, oth);
        check("fcr_wr_old_value", rd, 32'h0);
        do_txn(1, 1'b0, FND_FCR_OFS, 32'h0, rd, oth);
        check("m1_read_fcr", rd, 32'h1);
        check("m1_read_m0_ready", oth, 0);
        check("m0_rdata_held", m0_rdata[0], 32'h0);
        step();

        // m1 arrives during m0's ACCESS: both served once, m0 first.
        set_req(0, 1'b0, FND_FCR_OFS, 32'h0);
        step();
        set_req(1, 1'b0, FND_FDR_OFS, 32'h0);
        r0cnt = 0; r1cnt = 0; saw0 = 1'b0; saw1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (saw0) m0_req = 1'b0;
            if (saw1) m1_req = 1'b0;
            saw0 = m0_ready[0];
            saw1 = m1_ready[0];
            if (saw0) r0cnt++;
            if (saw1) begin
                r1cnt++;
                check("late_m1_first_after_m0", r0cnt, 1);
                check("late_m1_rdata_fdr", m1_rdata[0], 32'hD2);
            end
        end
        check("late_m0_count", r0cnt, 1);
        check("late_m1_count", r1cnt, 1);

        // Both held for 6 transactions from reset.
        rst = 1'b1;
        step();
        set_req(0, 1'b0, FND_FCR_OFS, 32'h0);
        set_req(1, 1'b0, FND_FDR_OFS, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 18; k++) begin
            step();
            if (m0_ready[0]) own_q0.push_back(1'b0);
            if (m1_ready[0]) own_q0.push_back(1'b1);
            if (m0_ready[1]) own_q1.push_back(1'b0);
            if (m1_ready[1]) own_q1.push_back(1'b1);
            if (s_cs[0]) cs_t.push_back(k);
        end
        check("rr_grants", own_q0.size(), 6);
        check("fp_grants", own_q1.size(), 6);
        check("rr_cs_count", cs_t.size(), 6);
        for (int i = 0; i < own_q0.size(); i++)
            check($sformatf("rr_owner_%0d", i), own_q0[i], i % 2);
        for (int i = 0; i < own_q1.size(); i++)
            check($sformatf("fp_owner_%0d", i), own_q1[i], 1'b0);
        for (int i = 0; i < cs_t.size(); i++)
            check($sformatf("rr_cs_spacing_%0d", i), cs_t[i], 3 * i);
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step(); step();

        // Reset during ACCESS aborts; afterwards m0 wins the tie.
        set_req(0, 1'b1, FND_FDR_OFS, 32'h55);
        step();
        check("abort_s_cs_before", s_cs[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_s_cs_async", s_cs[0], 1'b0);
        check("abort_busy_async", busy[0], 1'b0);
        step();
        check("abort_no_ready", m0_ready[0], 1'b0);
        set_req(1, 1'b0, FND_FCR_OFS, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_cs", s_cs[0], 1'b1);
        check("post_rst_owner_addr", s_addr[0], 32'h4);
        step();
        check("post_rst_m0_ready", m0_ready[0], 1'b1);
        check("post_rst_m1_ready", m1_ready[0], 1'b0);
        step();
        m0_req = 1'b0;
        step(); step();
        check("post_rst_m1_served", m1_ready[0], 1'b1);
        step();
        m1_req = 1'b0;
        step();

        // Randomised traffic under the handshake rules.
        saw0 = 1'b0; saw1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (saw0) m0_req = 1'b0;
            else if (!m0_req && $urandom_range(0, 1) == 1)
                set_req(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? FND_FDR_OFS : FND_FCR_OFS, $urandom);
            if (saw1) m1_req = 1'b0;
            else if (!m1_req && $urandom_range(0, 1) == 1)
                set_req(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? FND_FDR_OFS : FND_FCR_OFS, $urandom);
            saw0 = m0_ready[0];
            saw1 = m1_ready[0];
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
